// File: rtl/ball_motion_ctrl.sv
// Falling-ball position controller: steps one ball per frame tick through
// spawn, leftward roll, player-triggered drop, landing hold and respawn.
module ball_motion_ctrl #(
    parameter logic [15:0] START_COL   = 16'd632,
    parameter logic [15:0] INIT_ROW    = 16'd256,
    parameter logic [15:0] H_STEP      = 16'd2,
    parameter logic [15:0] V_STEP      = 16'd4,
    parameter logic [15:0] MAX_ROW     = 16'd479,
    parameter logic [7:0]  HOLD_FRAMES = 8'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame,
    input  logic        enable,
    input  logic        down_req,
    input  logic        downout,
    input  logic        newball,
    input  logic [15:0] newballrow,
    output logic [15:0] ballrow,
    output logic [15:0] ballcol,
    output logic        down,
    output logic        spawn,
    output logic        landed,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_SPAWN  = 2'd0,
        S_ROLL   = 2'd1,
        S_DROP   = 2'd2,
        S_LANDED = 2'd3
    } state_t;

    state_t      st;
    logic        pend;
    logic [7:0]  hold_cnt;
    logic        tick;
    logic [16:0] col_dec;
    logic [16:0] row_inc;
    logic [15:0] col_next;
    logic [15:0] row_next;

    assign tick  = frame & enable;
    assign state = st;

    // 17-bit math so the column saturates at 0 and the row clamps at MAX_ROW.
    always_comb begin
        col_dec  = {1'b0, ballcol} - {1'b0, H_STEP};
        col_next = col_dec[16] ? 16'd0 : col_dec[15:0];
        row_inc  = {1'b0, ballrow} + {1'b0, V_STEP};
        row_next = (row_inc > {1'b0, MAX_ROW}) ? MAX_ROW : row_inc[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_SPAWN;
            ballrow  <= INIT_ROW;
            ballcol  <= START_COL;
            down     <= 1'b0;
            spawn    <= 1'b0;
            landed   <= 1'b0;
            pend     <= 1'b0;
            hold_cnt <= 8'd0;
        end else begin
            spawn  <= 1'b0;
            landed <= 1'b0;
            // A drop request is latched between frames while rolling.
            if (enable && down_req && st == S_ROLL)
                pend <= 1'b1;
            if (tick) begin
                case (st)
                    S_SPAWN: begin
                        ballrow <= newballrow;
                        ballcol <= START_COL;
                        down    <= 1'b0;
                        pend    <= 1'b0;
                        spawn   <= 1'b1;
                        st      <= S_ROLL;
                    end
                    S_ROLL: begin
                        if (newball) begin
                            st <= S_SPAWN;
                        end else begin
                            ballcol <= col_next;
                            if (pend || down_req) begin
                                down <= 1'b1;
                                pend <= 1'b0;
                                st   <= S_DROP;
                            end
                        end
                    end
                    S_DROP: begin
                        if (newball) begin
                            down <= 1'b0;
                            st   <= S_SPAWN;
                        end else if (downout) begin
                            ballrow <= row_next;
                            ballcol <= col_next;
                        end else begin
                            landed   <= 1'b1;
                            hold_cnt <= 8'd0;
                            st       <= S_LANDED;
                        end
                    end
                    S_LANDED: begin
                        if (hold_cnt == HOLD_FRAMES - 8'd1) begin
                            hold_cnt <= 8'd0;
                            down     <= 1'b0;
                            st       <= S_SPAWN;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                    default: st <= S_SPAWN;
                endcase
            end
        end
    end

endmodule
